// File: rtl/ksa_swap.sv
// RC4 key-scheduling stage.
// Walks i over 0..255 and performs j = j + s[i] + key[i mod KEY_BYTES] and
// swap(s[i], s[j]) against a shared 256x8 synchronous S memory. Each
// iteration takes six cycles: read s[i], capture it, read s[j], capture it,
// write s[i], write s[j]. The memory-side interface matches the
// initialiser's, so the top level can mux the two blocks by task_on.
module ksa_swap #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             q,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wr_en,
  output logic                   task_on,
  output logic                   fin_strobe
);

  localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIW-1:0] KIDX_LAST = KIW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    GET_I = 3'd2,
    RD_J  = 3'd3,
    GET_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]             i_q;
  logic [7:0]             j_q;
  logic [7:0]             si_q;
  logic [7:0]             sj_q;
  logic [KIW-1:0]         key_idx;
  logic [8*KEY_BYTES-1:0] key_q;

  // Key byte 0 sits in the most significant byte of the key vector.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] k,
                                          input logic [KIW-1:0]         idx);
    logic [7:0] r;
    r = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (idx == KIW'(b)) r = k[8*(KEY_BYTES-1-b) +: 8];
    end
    return r;
  endfunction

  // Index arithmetic wraps modulo 256; there is deliberately no saturation.
  function automatic logic [7:0] wrap_add3(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
    logic [7:0] r;
    r = a + b + c;
    return r;
  endfunction

  // Key index is a plain modulo counter so no divider is needed for i mod KEY_BYTES.
  function automatic logic [KIW-1:0] next_key_idx(input logic [KIW-1:0] idx);
    logic [KIW-1:0] r;
    if (idx == KIDX_LAST) r = '0;
    else                  r = idx + KIW'(1);
    return r;
  endfunction

  // State register; reset aborts any run and returns to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing: six states per iteration, DONE after i==255.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RD_I;
      RD_I:    state_nxt = GET_I;
      GET_I:   state_nxt = RD_J;
      RD_J:    state_nxt = GET_J;
      GET_J:   state_nxt = WR_I;
      WR_I:    state_nxt = WR_J;
      WR_J:    state_nxt = (i_q == 8'hFF) ? DONE : RD_I;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index, swap operands and latched key; the key copy makes mid-run key changes harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_idx <= '0;
      key_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            key_idx <= '0;
            key_q   <= key;
          end
        end
        GET_I: begin
          si_q <= q;
          j_q  <= wrap_add3(j_q, q, key_byte(key_q, key_idx));
        end
        GET_J: begin
          sj_q <= q;
        end
        WR_J: begin
          if (i_q != 8'hFF) begin
            i_q     <= i_q + 8'd1;
            key_idx <= next_key_idx(key_idx);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory-side outputs decoded from state and registers only (q never reaches an output).
  always_comb begin
    address    = 8'd0;
    data       = 8'd0;
    wr_en      = 1'b0;
    task_on    = 1'b0;
    fin_strobe = 1'b0;
    unique case (state)
      IDLE: begin
      end
      RD_I, GET_I: begin
        address = i_q;
        task_on = 1'b1;
      end
      RD_J, GET_J: begin
        address = j_q;
        task_on = 1'b1;
      end
      WR_I: begin
        address = i_q;
        data    = sj_q;
        wr_en   = 1'b1;
        task_on = 1'b1;
      end
      WR_J: begin
        address = j_q;
        data    = si_q;
        wr_en   = 1'b1;
        task_on = 1'b1;
      end
      DONE: begin
        fin_strobe = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_swap.sv
// Testbench for ksa_swap: a synchronous 256x8 RAM model, a software RC4 KSA
// reference, and directed runs with randomized keys and initial images.
module tb_ksa_swap;

  localparam int MAXC = 3200;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] key;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wr_en;
  logic        task_on;
  logic        fin_strobe;

  logic [7:0]  mem      [256];
  logic [7:0]  init_img [256];
  logic [7:0]  ref_s    [256];
  logic        load_req;

  logic [7:0]  la [0:MAXC];
  logic [7:0]  ld [0:MAXC];
  logic        lw [0:MAXC];
  logic        lt [0:MAXC];
  logic        lf [0:MAXC];

  int n_pass  = 0;
  int n_total = 0;

  ksa_swap #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .q          (q),
    .address    (address),
    .data       (data),
    .wr_en      (wr_en),
    .task_on    (task_on),
    .fin_strobe (fin_strobe)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registered read, writes visible to the next read.
  always @(posedge clk) begin
    if (load_req) mem <= init_img;
    else if (wr_en) mem[address] <= data;
    q <= mem[address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill memory (identity or random bytes) and mirror it into the reference.
  task automatic load_image(input bit rnd);
    for (int k = 0; k < 256; k++) begin
      init_img[k] = rnd ? 8'($urandom) : 8'(k);
      ref_s[k]    = init_img[k];
    end
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Textbook RC4 key scheduling on the reference array.
  task automatic ref_ksa(input logic [23:0] k);
    int j;
    logic [7:0] t;
    logic [7:0] kb;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = k[8*(2 - (i % 3)) +: 8];
      j = (j + int'(ref_s[i]) + int'(kb)) % 256;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  // Start a run and log the outputs of cycles 1..n (cycle 1 = first cycle after acceptance).
  task automatic run(input int n, input bit pulse10, input bit hold, input bit toggle);
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      tick();
      start = (pulse10 && c == 10) || (hold && c >= 1537 && c <= 1538);
      if (toggle) key = 24'($urandom);
      la[c] = address;
      ld[c] = data;
      lw[c] = wr_en;
      lt[c] = task_on;
      lf[c] = fin_strobe;
    end
    start = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // One pass whose first RD_I is at logged cycle base.
  task automatic check_timing(input string tag, input int base);
    int bt, bf, bw, rel;
    bt = 0; bf = 0; bw = 0;
    for (int c = base; c <= base + 1536; c++) begin
      rel = c - base + 1;
      if (lt[c] !== (rel <= 1536)) bt++;
      if (lf[c] !== (rel == 1537)) bf++;
      if (lw[c] !== (rel <= 1536 && (rel % 6 == 5 || rel % 6 == 0))) bw++;
    end
    check({tag, "_task_on"}, 32'(bt), 32'd0);
    check({tag, "_fin"},     32'(bf), 32'd0);
    check({tag, "_wr_en"},   32'(bw), 32'd0);
  endtask

  initial begin
    logic [23:0] k;
    int nf, nt;

    rst = 1'b1; start = 1'b0; key = 24'd0; load_req = 1'b0;
    tick(); tick();
    check("reset_outputs", {13'd0, address, data, wr_en, task_on, fin_strobe}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_outputs", {13'd0, address, data, wr_en, task_on, fin_strobe}, 32'd0);

    // Identity S, key 010203: directed first-iteration timing.
    load_image(1'b0);
    key = 24'h010203;
    ref_ksa(key);
    run(1538, 1'b0, 1'b0, 1'b0);
    check("c1_addr_i",   {24'd0, la[1]}, 32'd0);
    check("c3_addr_j",   {24'd0, la[3]}, 32'd1);
    check("c5_write_si", {15'd0, la[5], ld[5], lw[5]}, {15'd0, 8'd0, 8'd1, 1'b1});
    check("c6_write_sj", {15'd0, la[6], ld[6], lw[6]}, {15'd0, 8'd1, 8'd0, 1'b1});
    check("c9_addr_j2",  {24'd0, la[9]}, 32'd3);
    check_timing("k010203", 1);
    check("k010203_idle_after", {31'd0, lt[1538]}, 32'd0);
    check_mem("k010203_mem");

    // Identity S, all-zero key: i==j self-swap in iteration 0.
    load_image(1'b0);
    key = 24'h000000;
    ref_ksa(key);
    run(1538, 1'b0, 1'b0, 1'b0);
    check("k0_c3_addr_j", {24'd0, la[3]}, 32'd0);
    check("k0_c5_write",  {15'd0, la[5], ld[5], lw[5]}, {15'd0, 8'd0, 8'd0, 1'b1});
    check("k0_c6_write",  {15'd0, la[6], ld[6], lw[6]}, {15'd0, 8'd0, 8'd0, 1'b1});
    check_mem("k0_mem");

    // key 00033C full run.
    load_image(1'b0);
    key = 24'h00033C;
    ref_ksa(key);
    run(1538, 1'b0, 1'b0, 1'b0);
    check_timing("k33c", 1);
    check("k33c_fin_1537", {31'd0, lf[1537]}, 32'd1);
    check_mem("k33c_mem");

    // start pulse while busy, then start held across DONE: back-to-back runs.
    load_image(1'b0);
    k = 24'($urandom);
    key = k;
    run(3076, 1'b1, 1'b1, 1'b0);
    ref_ksa(k);
    ref_ksa(k);
    check_timing("restart_run1", 1);
    check("restart_idle_1538", {31'd0, lt[1538]}, 32'd0);
    check("restart_begin_1539", {23'd0, lt[1539], la[1539]}, {23'd0, 1'b1, 8'd0});
    check_timing("restart_run2", 1539);
    check_mem("restart_mem");

    // Key toggled randomly during the run: latched copy must be used.
    load_image(1'b0);
    k = 24'($urandom);
    key = k;
    ref_ksa(k);
    run(1538, 1'b0, 1'b0, 1'b1);
    check_mem("keytoggle_mem");

    // Random initial image with random key.
    load_image(1'b1);
    k = 24'($urandom);
    key = k;
    ref_ksa(k);
    run(1538, 1'b0, 1'b0, 1'b0);
    check_timing("rndimg", 1);
    check_mem("rndimg_mem");

    // Asynchronous reset in the middle of a WR_I cycle (cycle 701).
    load_image(1'b0);
    key = 24'($urandom);
    start = 1'b1;
    for (int c = 1; c <= 701; c++) begin
      tick();
      start = 1'b0;
    end
    check("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", {13'd0, address, data, wr_en, task_on, fin_strobe}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    nf = 0; nt = 0;
    for (int c = 0; c < 1600; c++) begin
      tick();
      if (fin_strobe !== 1'b0) nf++;
      if (task_on !== 1'b0) nt++;
    end
    check("rst_no_fin", 32'(nf), 32'd0);
    check("rst_stays_idle", 32'(nt), 32'd0);
    load_image(1'b0);
    k = 24'($urandom);
    key = k;
    ref_ksa(k);
    run(1538, 1'b0, 1'b0, 1'b0);
    check_timing("post_rst", 1);
    check_mem("post_rst_mem");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
